iir_biquad_mc: RTL and testbench
================================

IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter COEF_W, default 16, coefficient width (signed).
REQ-003 SHALL have parameter FRAC_W, default 14, coefficient fraction bits (Q2.14 at defaults).
REQ-004 SHALL have parameter NUM_CH, default 2, number of independent channels, range 1..8.
REQ-005 SHALL have port clk, input, 1, single clock. All logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port sample_valid, input, 1, one-cycle strobe marking a new sample frame.
REQ-008 SHALL have port sample_in, input, NUM_CH*DATA_W, packed frame, channel k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have ports b0, b1, b2, a1, a2, input, COEF_W each, coefficients shared by all channels.
REQ-010 SHALL have port clear_state, input, 1, zeroes all channel history.
REQ-011 SHALL have port sample_out, output, NUM_CH*DATA_W, filtered frame, same packing as sample_in.
REQ-012 SHALL have port out_valid, output, 1, one-cycle strobe marking sample_out as updated.
REQ-013 SHALL have port busy, output, 1, high while a frame is processed.
REQ-014 SHALL have port overrun, output, 1, sticky flag for a dropped frame.

Function
REQ-015 SHALL compute, per channel, y[n] = (b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) >>> FRAC_W.
REQ-016 SHALL accumulate in a signed register of DATA_W+COEF_W+3 bits, with no intermediate overflow.
REQ-017 SHALL truncate the result by arithmetic right shift (floor); no rounding.
REQ-018 SHALL use one shared multiplier, time-multiplexed over 5 products per channel.
REQ-019 SHALL implement FSM states IDLE, MAC, WRITE, DONE.
REQ-020 IDLE->MAC on sample_valid: latch sample_in and all five coefficients, clear the accumulator, set channel index 0, assert busy.
REQ-021 MAC SHALL last exactly 5 cycles per channel (tap order b0,b1,b2,a1,a2), then go to WRITE.
REQ-022 WRITE (1 cycle) SHALL store y into that channel's slot of sample_out, shift history (x2<=x1, x1<=x, y2<=y1, y1<=y), clear the accumulator, then go to MAC for the next channel or to DONE after channel NUM_CH-1.
REQ-023 DONE (1 cycle) SHALL pulse out_valid, deassert busy, and return to IDLE.
REQ-024 Latency: out_valid SHALL assert exactly 6*NUM_CH+1 cycles after the accept edge (13 at NUM_CH=2).
REQ-025 The filter SHALL ignore sample_valid while busy: set overrun=1 and leave frame and state unaffected.
REQ-026 If sample_valid coincides with DONE, the filter SHALL count the frame as overrun and drop it.
REQ-027 Coefficient changes while busy SHALL NOT affect the frame in flight.
REQ-028 The filter SHALL honour clear_state only in IDLE: zero x1,x2,y1,y2 of all channels, sample_out unchanged. Ignore it otherwise.
REQ-029 If clear_state and sample_valid occur together in IDLE, the filter SHALL apply the clear first; the frame then starts from zero history.
REQ-030 sample_out SHALL hold its value between out_valid pulses.

Reset
REQ-031 Reset SHALL force IDLE; sample_out=0, out_valid=0, busy=0, overrun=0, all history and accumulator 0.
REQ-032 Reset mid-frame SHALL abort the frame without an out_valid pulse. Reset has priority over all inputs.

Configuration
REQ-033 Macro IIR_SAT_EN defined: WRITE SHALL clamp the shifted result to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before output and before storage into y1.
REQ-034 Macro IIR_SAT_EN undefined: WRITE SHALL keep the low DATA_W bits (two's-complement wrap) for output and y1.

Verification
REQ-035 Passthrough: b0=16384, others 0, frame {ch0=1000, ch1=-2000} -> sample_out {1000,-2000}, out_valid exactly 13 cycles after accept.
REQ-036 Averaging: b0=b1=8192, ch0 frames 1000,1000,2000 -> outputs 500,1000,1500; ch1 fed 0 stays 0 (channel independence).
REQ-037 Feedback: b0=1638, a1=-14746, step 10000 on ch0 -> first outputs 999, 1898; monotonic rise toward ~9998.
REQ-038 Overflow: b0=32767, x=30000 -> 32767 with IIR_SAT_EN, -5538 without.
REQ-039 Overrun: second sample_valid 4 cycles after the first -> overrun=1, single out_valid, results match the first frame only.
REQ-040 Reset at cycle 7 of a frame -> no out_valid, all outputs 0. Next frame with b0=16384, x=1000 -> 1000.

Source files
------------

// File: rtl/iir_biquad_mc.sv
// Multi-channel direct-form-I biquad with one shared multiplier, 5 MAC cycles + 1 write cycle per channel.
// Define IIR_SAT_EN to clamp results to the DATA_W range instead of wrapping.
module iir_biquad_mc #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic [COEF_W-1:0]        b0,
  input  logic [COEF_W-1:0]        b1,
  input  logic [COEF_W-1:0]        b2,
  input  logic [COEF_W-1:0]        a1,
  input  logic [COEF_W-1:0]        a2,
  input  logic                     clear_state,
  output logic [NUM_CH*DATA_W-1:0] sample_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                    r_state;
  logic [CH_W-1:0]           r_ch;
  logic [2:0]                r_tap;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [COEF_W-1:0]  r_b0, r_b1, r_b2, r_a1, r_a2;
  logic signed [DATA_W-1:0]  r_x  [NUM_CH];
  logic signed [DATA_W-1:0]  r_x1 [NUM_CH];
  logic signed [DATA_W-1:0]  r_x2 [NUM_CH];
  logic signed [DATA_W-1:0]  r_y1 [NUM_CH];
  logic signed [DATA_W-1:0]  r_y2 [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]  r_sample_out;
  logic                      r_out_valid;
  logic                      r_busy;
  logic                      r_overrun;

  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_data;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_shift;
  logic signed [DATA_W-1:0]  w_y;

  // Tap order b0,b1,b2,a1,a2 selects coefficient and history operand for the current channel.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_coef = r_b0;
    w_data = r_x[r_ch];
    case (r_tap)
      3'd1:    begin w_coef = r_b1; w_data = r_x1[r_ch]; end
      3'd2:    begin w_coef = r_b2; w_data = r_x2[r_ch]; end
      3'd3:    begin w_coef = r_a1; w_data = r_y1[r_ch]; end
      3'd4:    begin w_coef = r_a2; w_data = r_y2[r_ch]; end
      default: begin w_coef = r_b0; w_data = r_x[r_ch];  end
    endcase
  end

  assign w_prod     = w_coef * w_data;
  assign w_prod_ext = {{3{w_prod[PROD_W-1]}}, w_prod};
  assign w_shift    = r_acc >>> FRAC_W;

`ifdef IIR_SAT_EN
  logic [ACC_W-DATA_W:0] w_hi;
  assign w_hi = w_shift[ACC_W-1:DATA_W-1];

  // In range only when every bit above the result's sign bit matches it.
  always_comb begin
    w_y = w_shift[DATA_W-1:0];
    if (!((&w_hi) || !(|w_hi)))
      w_y = w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign w_y = w_shift[DATA_W-1:0];
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_tap        <= '0;
      r_acc        <= '0;
      r_b0         <= '0;
      r_b1         <= '0;
      r_b2         <= '0;
      r_a1         <= '0;
      r_a2         <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      // NOTE: the history arrays are reset too; they are a handful of flops, not a RAM, and must start at zero.
      for (int k = 0; k < NUM_CH; k++) begin
        r_x[k]  <= '0;
        r_x1[k] <= '0;
        r_x2[k] <= '0;
        r_y1[k] <= '0;
        r_y2[k] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (sample_valid && r_state != IDLE) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (clear_state) begin
            for (int k = 0; k < NUM_CH; k++) begin
              r_x1[k] <= '0;
              r_x2[k] <= '0;
              r_y1[k] <= '0;
              r_y2[k] <= '0;
            end
          end
          if (sample_valid) begin
            for (int k = 0; k < NUM_CH; k++) r_x[k] <= sample_in[k*DATA_W +: DATA_W];
            r_b0    <= b0;
            r_b1    <= b1;
            r_b2    <= b2;
            r_a1    <= a1;
            r_a2    <= a2;
            r_acc   <= '0;
            r_ch    <= '0;
            r_tap   <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end

        MAC: begin
          r_acc <= (r_tap >= 3'd3) ? r_acc - w_prod_ext : r_acc + w_prod_ext;
          if (r_tap == 3'd4) begin
            r_tap   <= '0;
            r_state <= WRITE;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end

        WRITE: begin
          for (int k = 0; k < NUM_CH; k++)
            if (r_ch == CH_W'(k)) r_sample_out[k*DATA_W +: DATA_W] <= w_y;
          r_x2[r_ch] <= r_x1[r_ch];
          r_x1[r_ch] <= r_x[r_ch];
          r_y2[r_ch] <= r_y1[r_ch];
          r_y1[r_ch] <= w_y;
          r_acc      <= '0;
          if (r_ch == LAST_CH) begin
            r_state <= DONE;
          end else begin
            r_ch    <= r_ch + CH_W'(1);
            r_state <= MAC;
          end
        end

        DONE: begin
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign sample_out = r_sample_out;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc at default parameters (2 channels, Q2.14 coefficients).
// Expected values are hand-computed; the overflow case follows IIR_SAT_EN.
module tb_iir_biquad_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [31:0] sample_in;
  logic [15:0] b0, b1, b2, a1, a2;
  logic        clear_state;
  logic [31:0] sample_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int n_valid;

`ifdef IIR_SAT_EN
  localparam int EXP_OVF0 = 32767;
  localparam int EXP_OVF1 = -32768;
`else
  localparam int EXP_OVF0 = -5538;
  localparam int EXP_OVF1 = 5537;
`endif

  iir_biquad_mc dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .b0           (b0),
    .b1           (b1),
    .b2           (b2),
    .a1           (a1),
    .a2           (a2),
    .clear_state  (clear_state),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] ch_out(input int k);
    return sample_out[k*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        failures++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
  endtask

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3, input int c4);
    @(negedge clk);
    b0 = 16'(c0);
    b1 = 16'(c1);
    b2 = 16'(c2);
    a1 = 16'(c3);
    a2 = 16'(c4);
  endtask

  // Returns on the falling edge just after the accept edge.
  task automatic start_frame(input int x0, input int x1, input logic clr);
    @(negedge clk);
    sample_in    = {16'(x1), 16'(x0)};
    clear_state  = clr;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    clear_state  = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
  endtask

  // 'already' = falling edges elapsed since the accept edge; a timeout shows up as a latency failure.
  task automatic wait_done(input string tag, input int already);
    int lat;
    lat = already;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 13);
    @(negedge clk);
    check({tag, " pulse width"}, out_valid, 0);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    clear_state  = 1'b0;
    {b0, b1, b2, a1, a2} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset sample_out", sample_out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);

    // Passthrough and hold
    set_coef(16384, 0, 0, 0, 0);
    start_frame(1000, -2000, 1'b0);
    check("pass busy", busy, 1);
    wait_done("pass", 0);
    check("pass ch0", ch_out(0), 1000);
    check("pass ch1", ch_out(1), -2000);
    check("pass busy after", busy, 0);
    repeat (5) @(negedge clk);
    check("pass hold ch0", ch_out(0), 1000);

    // Two-tap average, ch1 stays silent
    pulse_clear();
    set_coef(8192, 8192, 0, 0, 0);
    start_frame(1000, 0, 1'b0);
    wait_done("avg1", 0);
    check("avg1 ch0", ch_out(0), 500);
    check("avg1 ch1", ch_out(1), 0);
    start_frame(1000, 0, 1'b0);
    wait_done("avg2", 0);
    check("avg2 ch0", ch_out(0), 1000);
    start_frame(2000, 0, 1'b0);
    wait_done("avg3", 0);
    check("avg3 ch0", ch_out(0), 1500);
    check("avg3 ch1", ch_out(1), 0);

    // Floor truncation of +/-1.5
    set_coef(8192, 0, 0, 0, 0);
    start_frame(-3, 3, 1'b0);
    wait_done("floor", 0);
    check("floor ch0", ch_out(0), -2);
    check("floor ch1", ch_out(1), 1);

    // First-order feedback step response
    pulse_clear();
    set_coef(1638, 0, 0, -14746, 0);
    start_frame(10000, 0, 1'b0);
    wait_done("fb1", 0);
    check("fb1 ch0", ch_out(0), 999);
    start_frame(10000, 0, 1'b0);
    wait_done("fb2", 0);
    check("fb2 ch0", ch_out(0), 1898);
    start_frame(10000, 0, 1'b0);
    wait_done("fb3", 0);
    check("fb3 ch0", ch_out(0), 2708);
    check("fb3 ch1", ch_out(1), 0);

    // clear_state alone, then together with sample_valid plus a coefficient change mid-frame
    pulse_clear();
    start_frame(10000, 0, 1'b0);
    wait_done("clr", 0);
    check("clr ch0", ch_out(0), 999);
    start_frame(10000, 0, 1'b1);
    b0 = 16'd0;
    a1 = 16'd0;
    wait_done("clrv", 0);
    check("clr+valid ch0", ch_out(0), 999);

    // Overflow: wrap or saturate depending on build
    set_coef(32767, 0, 0, 0, 0);
    start_frame(30000, -30000, 1'b0);
    wait_done("ovf", 0);
    check("ovf ch0", ch_out(0), EXP_OVF0);
    check("ovf ch1", ch_out(1), EXP_OVF1);

    // Overrun while in MAC
    check("ovr pre", overrun, 0);
    set_coef(16384, 0, 0, 0, 0);
    start_frame(100, 200, 1'b0);
    repeat (3) @(negedge clk);
    sample_in    = {16'(8888), 16'(7777)};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_done("ovr", 4);
    check("ovr ch0", ch_out(0), 100);
    check("ovr ch1", ch_out(1), 200);
    check("ovr flag", overrun, 1);
    count_valid(30, n_valid);
    check("ovr extra out_valid", n_valid, 0);
    check("ovr busy", busy, 0);

    // sample_valid coinciding with DONE is dropped
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2 overrun", overrun, 0);
    check("rst2 sample_out", sample_out, 0);
    start_frame(5, 6, 1'b0);
    repeat (12) @(negedge clk);
    check("done busy", busy, 1);
    sample_in    = {16'(222), 16'(111)};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_done("done", 13);
    check("done ch0", ch_out(0), 5);
    check("done ch1", ch_out(1), 6);
    check("done overrun", overrun, 1);
    check("done busy after", busy, 0);
    count_valid(30, n_valid);
    check("done extra out_valid", n_valid, 0);

    // Reset at cycle 7 of a frame aborts it
    start_frame(1000, 1000, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_valid(30, n_valid);
    check("abort out_valid", n_valid, 0);
    check("abort sample_out", sample_out, 0);
    check("abort busy", busy, 0);
    check("abort overrun", overrun, 0);
    start_frame(1000, 0, 1'b0);
    wait_done("post", 0);
    check("post ch0", ch_out(0), 1000);
    check("post ch1", ch_out(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
